cacheline_adaptor: RTL and testbench

- Sits directly downstream of the I/D memory arbiter, between the arbiter's single 256-bit cacheline port and the 64-bit burst physical memory.
- Converts one line read into a 4-beat read burst and one line write into a 4-beat write burst.
- Presents a single-pulse line-level response back to the arbiter.

---
 rtl/cacheline_adaptor_pkg.sv | 22 ++
 rtl/cacheline_adaptor.sv | 165 ++++++++++++++++
 tb/tb_cacheline_adaptor.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// Shared types for the cacheline adaptor: FSM state encoding, beat geometry
// and the address-alignment helper.
package cla_types;

    localparam int CLA_BEAT_W = 64;
    localparam int CLA_BEATS  = 4;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } cla_state_t;

    // Clears the byte-offset bits so memory always sees a line-aligned address.
    function automatic rv32i_word cla_align(input rv32i_word addr, input int offset_w);
        return addr & ~((32'd1 << offset_w) - 32'd1);
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cacheline port to a 64-bit, 4-beat burst memory.
// Optional performance counters are built when CACHELINE_ADAPTOR_PERF_EN is defined.
module cacheline_adaptor
    import cla_types::*;
#(
    parameter int BEAT_W = CLA_BEAT_W,
    parameter int BEATS  = CLA_BEATS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BEAT_W*BEATS-1:0]   line_i,
    output logic [BEAT_W*BEATS-1:0]   line_o,
    input  rv32i_word                 address_i,
    input  logic                      read_i,
    input  logic                      write_i,
    output logic                      resp_o,
    input  logic [BEAT_W-1:0]         burst_i,
    output logic [BEAT_W-1:0]         burst_o,
    output rv32i_word                 address_o,
    output logic                      read_o,
    output logic                      write_o,
    input  logic                      resp_i
`ifdef CACHELINE_ADAPTOR_PERF_EN
    ,
    output logic [31:0]               rd_lines_o,
    output logic [31:0]               wr_lines_o,
    output logic [31:0]               stall_cycles_o
`endif
);

    localparam int LINE_W     = BEAT_W * BEATS;
    localparam int OFFSET_W   = $clog2(LINE_W / 8);
    localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LSB_W      = $clog2(LINE_W);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

    cla_state_t              state_r;
    logic [BEAT_CNT_W-1:0]   beat_r;
    logic [LINE_W-1:0]       line_buf_r;
    rv32i_word               addr_r;
    logic [BEAT_W-1:0]       burst_r;
    logic                    read_r;
    logic                    write_r;
    logic                    resp_r;

    logic [BEAT_CNT_W-1:0]   beat_next_s;
    logic                    last_beat_s;
    logic [LSB_W-1:0]        cur_lsb_s;
    logic [LSB_W-1:0]        nxt_lsb_s;

    // Beat bookkeeping: next count and bit offsets of the current/next beat.
    always_comb begin
        beat_next_s = beat_r + BEAT_CNT_W'(1);
        last_beat_s = (beat_r == LAST_BEAT);
        cur_lsb_s   = LSB_W'(beat_r) * LSB_W'(BEAT_W);
        nxt_lsb_s   = LSB_W'(beat_next_s) * LSB_W'(BEAT_W);
    end

    // Line-transfer FSM; every memory/arbiter-facing control is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            beat_r     <= '0;
            line_buf_r <= '0;
            addr_r     <= 32'd0;
            burst_r    <= '0;
            read_r     <= 1'b0;
            write_r    <= 1'b0;
            resp_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    resp_r <= 1'b0;
                    // A write wins over a simultaneous read.
                    if (write_i) begin
                        line_buf_r <= line_i;
                        addr_r     <= cla_align(address_i, OFFSET_W);
                        beat_r     <= '0;
                        burst_r    <= line_i[BEAT_W-1:0];
                        write_r    <= 1'b1;
                        state_r    <= WRITE;
                    end else if (read_i) begin
                        addr_r  <= cla_align(address_i, OFFSET_W);
                        beat_r  <= '0;
                        read_r  <= 1'b1;
                        state_r <= READ;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_buf_r[cur_lsb_s +: BEAT_W] <= burst_i;
                        beat_r <= beat_next_s;
                        if (last_beat_s) begin
                            read_r  <= 1'b0;
                            resp_r  <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        beat_r  <= beat_next_s;
                        burst_r <= line_buf_r[nxt_lsb_s +: BEAT_W];
                        if (last_beat_s) begin
                            write_r <= 1'b0;
                            resp_r  <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                DONE: begin
                    resp_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    beat_r  <= '0;
                    read_r  <= 1'b0;
                    write_r <= 1'b0;
                    resp_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign line_o    = line_buf_r;
    assign burst_o   = burst_r;
    assign address_o = addr_r;
    assign read_o    = read_r;
    assign write_o   = write_r;
    assign resp_o    = resp_r;

`ifdef CACHELINE_ADAPTOR_PERF_EN
    logic [31:0] rd_lines_r;
    logic [31:0] wr_lines_r;
    logic [31:0] stall_cycles_r;

    // Saturating line and stall counters; line counts bump on the DONE-entry edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_lines_r     <= 32'd0;
            wr_lines_r     <= 32'd0;
            stall_cycles_r <= 32'd0;
        end else begin
            if ((state_r == READ) && resp_i && last_beat_s && (rd_lines_r != 32'hFFFF_FFFF)) begin
                rd_lines_r <= rd_lines_r + 32'd1;
            end
            if ((state_r == WRITE) && resp_i && last_beat_s && (wr_lines_r != 32'hFFFF_FFFF)) begin
                wr_lines_r <= wr_lines_r + 32'd1;
            end
            if (((state_r == READ) || (state_r == WRITE)) && !resp_i &&
                (stall_cycles_r != 32'hFFFF_FFFF)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end
        end
    end

    assign rd_lines_o     = rd_lines_r;
    assign wr_lines_o     = wr_lines_r;
    assign stall_cycles_o = stall_cycles_r;
`else
    // Without the perf build the adaptor carries no counter state.
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: a transaction-level timing model is
// checked against the DUT every cycle, plus literal expectations per scenario.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] line_i = '0;
    logic [255:0] line_o;
    logic [31:0]  address_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic         resp_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 1'b0;
`ifdef CACHELINE_ADAPTOR_PERF_EN
    logic [31:0]  rd_lines_o;
    logic [31:0]  wr_lines_o;
    logic [31:0]  stall_cycles_o;
`endif

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
`ifdef CACHELINE_ADAPTOR_PERF_EN
        ,
        .rd_lines_o     (rd_lines_o),
        .wr_lines_o     (wr_lines_o),
        .stall_cycles_o (stall_cycles_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Transaction model: request sampled at the end of cycle t0; beats land at
    // t0+exp_sched[i]; line busy for rel 1..last beat, resp one cycle later.
    bit           chk_en = 1'b0;
    bit           exp_active = 1'b0;
    bit           exp_wr = 1'b0;
    int           exp_t0 = 0;
    int           exp_sched[4] = '{0, 0, 0, 0};
    logic [255:0] exp_line = '0;
    logic [31:0]  exp_addr = '0;
    int           exp_rd_lines = 0;
    int           exp_wr_lines = 0;
    int           exp_stalls = 0;

    // Observations recorded by the compare process for literal checks.
    int           resp_cnt = 0;
    int           rd_hi_cnt = 0;
    int           last_resp_rel = -1;
    logic [31:0]  last_addr_seen = '0;
    logic [255:0] last_line_seen = '0;
    logic [63:0]  wr_seen[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare of every DUT output against the model.
    initial begin
        int  rel;
        int  k;
        bit  in_burst;
        bit  e_rd;
        bit  e_wr;
        bit  e_resp;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                rel      = cyc - exp_t0;
                in_burst = exp_active && (rel >= 1) && (rel <= exp_sched[3]);
                e_rd     = in_burst && !exp_wr;
                e_wr     = in_burst && exp_wr;
                e_resp   = exp_active && (rel == exp_sched[3] + 1);
                check("read_o", 256'(read_o), 256'(e_rd));
                check("write_o", 256'(write_o), 256'(e_wr));
                check("resp_o", 256'(resp_o), 256'(e_resp));
                if (in_burst) begin
                    check("address_o", 256'(address_o), 256'(exp_addr));
                    last_addr_seen = address_o;
                end
                if (e_wr) begin
                    k = 0;
                    for (int j = 0; j < 4; j++) if (exp_sched[j] < rel) k++;
                    check("burst_o", 256'(burst_o), 256'(64'(exp_line >> (64 * k))));
                    if (resp_i) wr_seen.push_back(burst_o);
                end
                if (e_resp && !exp_wr) check("line_o", line_o, exp_line);
                if (resp_o === 1'b1) begin
                    resp_cnt++;
                    last_resp_rel  = rel;
                    last_line_seen = line_o;
                end
                if (read_o === 1'b1) rd_hi_cnt++;
            end
        end
    end

    task automatic run_txn(input bit do_rd, input bit do_wr, input logic [31:0] addr,
                           input logic [255:0] line, input logic [255:0] beats,
                           input int s0, input int s1, input int s2, input int s3);
        int b;
        @(posedge clk); #1;
        exp_t0    = cyc;
        exp_sched = '{s0, s1, s2, s3};
        exp_wr    = do_wr;
        exp_addr  = {addr[31:5], 5'd0};
        exp_line  = do_wr ? line : beats;
        exp_active = 1'b1;
        if (do_wr) exp_wr_lines++;
        else exp_rd_lines++;
        exp_stalls += s3 - 4;
        read_i = do_rd; write_i = do_wr; address_i = addr; line_i = line; resp_i = 1'b0;
        b = 0;
        for (int rel = 1; rel <= s3 + 3; rel++) begin
            @(posedge clk); #1;
            // Request payload scrambled after acceptance must not matter.
            if (rel >= 2) begin
                address_i = $urandom;
                line_i    = {8{$urandom}};
            end
            if ((b < 4) && (rel == exp_sched[b])) begin
                resp_i  = 1'b1;
                burst_i = 64'(beats >> (64 * b));
                b++;
            end else begin
                resp_i  = 1'b0;
                burst_i = {$urandom, $urandom};
            end
            if (rel == s3 + 1) begin
                read_i  = 1'b0;
                write_i = 1'b0;
            end
        end
        resp_i = 1'b0;
        exp_active = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int           r0;
        logic [255:0] rd1_beats;
        logic [255:0] gap_beats;
        logic [255:0] wr_line;
        logic [63:0]  wr_lits[4];

        rd1_beats = {64'h4444444444444444, 64'h3333333333333333,
                     64'h2222222222222222, 64'h1111111111111111};
        gap_beats = {64'hDDDD0000DDDD0004, 64'hCCCC0000CCCC0003,
                     64'hBBBB0000BBBB0002, 64'hAAAA0000AAAA0001};
        wr_line   = 256'h0123456789abcdef_fedcba9876543210_0011223344556677_8899aabbccddeeff;
        wr_lits   = '{64'h8899aabbccddeeff, 64'h0011223344556677,
                      64'hfedcba9876543210, 64'h0123456789abcdef};

        // Reset state.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_read_o", 256'(read_o), 256'd0);
        check("rst_write_o", 256'(write_o), 256'd0);
        check("rst_resp_o", 256'(resp_o), 256'd0);
        check("rst_address_o", 256'(address_o), 256'd0);
        check("rst_burst_o", 256'(burst_o), 256'd0);
        check("rst_line_o", line_o, 256'd0);

        // Stray resp_i in IDLE must be ignored.
        @(posedge clk); #1 resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk); #1 resp_i = 1'b0;
        @(negedge clk);
        check("idle_resp_ignored_line", line_o, 256'd0);

        // Reset after the 2nd read beat aborts the burst.
        @(posedge clk); #1;
        r0 = resp_cnt;
        exp_t0 = cyc; exp_sched = '{3, 4, 100, 101}; exp_wr = 1'b0;
        exp_addr = 32'h0000_5660; exp_line = '0; exp_active = 1'b1;
        read_i = 1'b1; address_i = 32'h0000_5678;
        for (int rel = 1; rel <= 5; rel++) begin
            @(posedge clk); #1;
            resp_i  = (rel == 3) || (rel == 4);
            burst_i = {$urandom, $urandom};
            if (rel == 5) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0; read_i = 1'b0; resp_i = 1'b0; exp_active = 1'b0;
        exp_rd_lines = 0; exp_wr_lines = 0; exp_stalls = 0;
        @(negedge clk);
        check("abort_line_cleared", line_o, 256'd0);
        check("abort_addr_cleared", 256'(address_o), 256'd0);
        repeat (4) @(posedge clk);
        check("abort_no_resp", 256'(resp_cnt - r0), 256'd0);

        // Read, memory latency 3.
        r0 = resp_cnt;
        run_txn(1'b1, 1'b0, 32'h0000_1234, '0, rd1_beats, 3, 4, 5, 6);
        check("rd1_addr", 256'(last_addr_seen), 256'(32'h0000_1220));
        check("rd1_line", last_line_seen,
              {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111});
        check("rd1_resp_rel", 256'(last_resp_rel), 256'd7);
        check("rd1_resp_pulses", 256'(resp_cnt - r0), 256'd1);

        // Write burst with one mid-burst stall.
        wr_seen.delete();
        r0 = resp_cnt;
        run_txn(1'b0, 1'b1, 32'h8000_0040, wr_line, '0, 2, 3, 5, 6);
        for (int k = 0; k < 4; k++)
            check("wr_beat", (k < wr_seen.size()) ? 256'(wr_seen[k]) : {256{1'bx}}, 256'(wr_lits[k]));
        check("wr_addr", 256'(last_addr_seen), 256'(32'h8000_0040));
        check("wr_resp_pulses", 256'(resp_cnt - r0), 256'd1);

        // Read with resp_i gaps.
        run_txn(1'b1, 1'b0, 32'h0000_ABCD, '0, gap_beats, 4, 6, 9, 10);
        check("gap_resp_rel", 256'(last_resp_rel), 256'd11);
        check("gap_line", last_line_seen, gap_beats);
        check("gap_addr", 256'(last_addr_seen), 256'(32'h0000_ABC0));

        // Simultaneous read and write: write wins.
        wr_seen.delete();
        r0 = rd_hi_cnt;
        run_txn(1'b1, 1'b1, 32'h0000_0100, ~wr_line, '0, 1, 2, 3, 4);
        check("both_no_read_o", 256'(rd_hi_cnt - r0), 256'd0);
        check("both_wr_beats", 256'(wr_seen.size()), 256'd4);

`ifdef CACHELINE_ADAPTOR_PERF_EN
        @(negedge clk);
        check("perf_rd_lines", 256'(rd_lines_o), 256'(exp_rd_lines));
        check("perf_wr_lines", 256'(wr_lines_o), 256'(exp_wr_lines));
        check("perf_stalls", 256'(stall_cycles_o), 256'(exp_stalls));
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
